hf_freq_counter: RTL and testbench

//  - Upstream feeder of the Huffman encoder stage. Consumes a stream of 3-bit symbol IDs (a..e)
//    one per cycle and counts the occurrences of each symbol over one frame.
//  - At frame end it presents the five counts as the packed 25-bit symbol_freq word that the

---
 rtl/hf_pkg.sv | 43 ++++
 rtl/hf_sym_counter.sv | 55 +++++
 rtl/hf_freq_counter.sv | 135 +++++++++++++
 tb/tb_hf_freq_counter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hf_pkg.sv
// ---------------------------------------------------------------------------
// hf_pkg
// Shared definitions for the Huffman symbol-frequency front end.
//   - Symbol IDs a..e (SYM_A..SYM_E); IDs above SYM_E are illegal.
//   - SYM_NUM / CNT_W / FREQ_W: symbol count, per-symbol count width and
//     the width of the packed frequency word handed to the encoder.
//   - state_e: frame FSM encoding (IDLE = no frame open, ACCUM = frame open).
//   - satInc: saturating increment shared by the counters and the
//     frame-end snapshot so both agree on where a count stops.
// ---------------------------------------------------------------------------
package hf_pkg;

  localparam logic [2:0] SYM_A = 3'd0;
  localparam logic [2:0] SYM_B = 3'd1;
  localparam logic [2:0] SYM_C = 3'd2;
  localparam logic [2:0] SYM_D = 3'd3;
  localparam logic [2:0] SYM_E = 3'd4;

  localparam int SYM_NUM = 5;
  localparam int CNT_W   = 5;
  localparam int FREQ_W  = SYM_NUM * CNT_W;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Returns {hitCeiling, value}: value is cnt+inc clamped at CNT_MAX, and
  // hitCeiling flags an increment that was swallowed by the clamp.
  function automatic logic [CNT_W:0] satInc(input logic [CNT_W-1:0] cnt,
                                            input logic             inc);
    logic [CNT_W:0] res;
    if (inc && (cnt == CNT_MAX)) begin
      res = {1'b1, cnt};
    end else begin
      res = {1'b0, cnt + CNT_W'(inc)};
    end
    return res;
  endfunction

endpackage

// File: rtl/hf_sym_counter.sv
// ---------------------------------------------------------------------------
// hf_sym_counter
// One per-symbol occurrence counter, saturating at CNT_MAX.
// Ports:
//   clk, rst_n  : clock / asynchronous active-low reset
//   inc_i       : add one occurrence this cycle
//   clr_i       : start over from zero (wins over the old value; inc_i is
//                 then added on top of the cleared value)
//   count_o     : current count
//   sat_o       : sticky flag, an increment was lost at the ceiling since
//                 the last clear
// ---------------------------------------------------------------------------
module hf_sym_counter
  import hf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [CNT_W:0]   bumped;

  // Next count: clear has priority, otherwise a clamped increment whose
  // overflow attempt latches the saturation flag.
  always_comb begin
    bumped = satInc(count_q, inc_i);
    if (clr_i) begin
      count_d = CNT_W'(inc_i);
      sat_d   = 1'b0;
    end else begin
      count_d = bumped[CNT_W-1:0];
      sat_d   = sat_q | bumped[CNT_W];
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/hf_freq_counter.sv
// ---------------------------------------------------------------------------
// hf_freq_counter
// Counts occurrences of symbols a..e over a frame and, on frame end,
// publishes the five counts as one packed word for the Huffman encoder.
// Frames end on in_last or after MAX_FRAME accepted symbols; the next frame
// may start on the very next cycle.
// Ports:
//   clk, rst_n   : clock / asynchronous active-low reset
//   in_valid     : in_symbol / in_last valid this cycle
//   in_symbol    : 0..4 = a..e, 5..7 illegal
//   in_last      : last beat of the frame (legal or illegal symbol)
//   out_valid    : one-cycle pulse, symbol_freq holds a finished frame
//   symbol_freq  : {a,b,c,d,e} counts, held until the next frame end
//   out_sat      : some count of the published frame saturated
//   err_sym      : one-cycle pulse, an illegal symbol was received
// ---------------------------------------------------------------------------
module hf_freq_counter
  import hf_pkg::*;
#(
  parameter int MAX_FRAME = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [2:0]        in_symbol,
  input  logic              in_last,
  output logic              out_valid,
  output logic [FREQ_W-1:0] symbol_freq,
  output logic              out_sat,
  output logic              err_sym
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_FRAME);

  logic               accepted, illegal, frameEnd;
  logic [SYM_NUM-1:0] hit;
  logic [CNT_W-1:0]   cnt [SYM_NUM];
  logic [SYM_NUM-1:0] cntSat;
  logic [7:0]         lenNext;
  logic [7:0]         frameLen_q, frameLen_d;
  state_e             state_q, state_d;
  logic               outValid_q, outValid_d;
  logic               outSat_q, outSat_d;
  logic               errSym_q, errSym_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [FREQ_W-1:0]  snapWord;
  logic               snapSat;
  logic [CNT_W:0]     bumped;

  // Beat decode: a frame also ends when this accepted beat fills the
  // frame to MAX_FRAME symbols, even without in_last.
  always_comb begin
    hit      = '0;
    accepted = in_valid && (in_symbol <= SYM_E);
    illegal  = in_valid && (in_symbol > SYM_E);
    lenNext  = frameLen_q + 8'd1;
    frameEnd = (in_valid && in_last) || (accepted && (lenNext == MAX_LEN));
    for (int k = 0; k < SYM_NUM; k++) begin
      hit[k] = accepted && (in_symbol == 3'(k));
    end
  end

  // On the frame-end beat the counters are cleared rather than bumped, so
  // that beat's own symbol must not leak into the next frame.
  for (genvar g = 0; g < SYM_NUM; g++) begin : g_cnt
    hf_sym_counter u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (hit[g] & ~frameEnd),
      .clr_i   (frameEnd),
      .count_o (cnt[g]),
      .sat_o   (cntSat[g])
    );
  end

  // Frame-end snapshot: the counts as they would be including the
  // current beat, packed with symbol a in the most significant field.
  always_comb begin
    snapWord = '0;
    snapSat  = 1'b0;
    bumped   = '0;
    for (int k = 0; k < SYM_NUM; k++) begin
      bumped = satInc(cnt[k], hit[k]);
      snapWord[FREQ_W-1-k*CNT_W -: CNT_W] = bumped[CNT_W-1:0];
      snapSat = snapSat | cntSat[k] | bumped[CNT_W];
    end
  end

  // Frame FSM plus length counter and output register next-state.
  always_comb begin
    state_d    = state_q;
    frameLen_d = frameLen_q;
    freq_d     = freq_q;
    outSat_d   = outSat_q;
    outValid_d = frameEnd;
    errSym_d   = illegal;
    case (state_q)
      IDLE:    if (accepted && !frameEnd) state_d = ACCUM;
      ACCUM:   if (frameEnd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (frameEnd) begin
      frameLen_d = '0;
      freq_d     = snapWord;
      outSat_d   = snapSat;
    end else if (accepted) begin
      frameLen_d = lenNext;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frameLen_q <= '0;
      outValid_q <= 1'b0;
      freq_q     <= '0;
      outSat_q   <= 1'b0;
      errSym_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      frameLen_q <= frameLen_d;
      outValid_q <= outValid_d;
      freq_q     <= freq_d;
      outSat_q   <= outSat_d;
      errSym_q   <= errSym_d;
    end
  end

  assign out_valid   = outValid_q;
  assign symbol_freq = freq_q;
  assign out_sat     = outSat_q;
  assign err_sym     = errSym_q;

endmodule

// File: tb/tb_hf_freq_counter.sv
// ---------------------------------------------------------------------------
// tb_hf_freq_counter
// Two instances share one input stream: one with the default 31-symbol
// frame limit and one with a 40-symbol limit, so that both the forced
// frame end and count saturation are reachable. A frame-level reference
// model predicts every published frame and error pulse.
// ---------------------------------------------------------------------------
module tb_hf_freq_counter;
  import hf_pkg::*;

  typedef struct {
    int                stamp;
    logic [FREQ_W-1:0] word;
    logic              sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [2:0]        in_symbol = 3'd0;
  logic              in_last = 1'b0;

  logic              ov0, os0, es0, ov1, os1, es1;
  logic [FREQ_W-1:0] sf0, sf1;

  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  logic              endReq = 1'b0;

  exp_t              q0[$];
  exp_t              q1[$];
  int                errQ[$];

  int                mCnt[2][SYM_NUM];
  int                mLen[2];
  int                maxF[2] = '{31, 40};
  logic [FREQ_W-1:0] heldW[2];
  logic              heldS[2];

  hf_freq_counter #(.MAX_FRAME(31)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_symbol(in_symbol),
    .in_last(in_last), .out_valid(ov0), .symbol_freq(sf0), .out_sat(os0),
    .err_sym(es0)
  );

  hf_freq_counter #(.MAX_FRAME(40)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_symbol(in_symbol),
    .in_last(in_last), .out_valid(ov1), .symbol_freq(sf1), .out_sat(os1),
    .err_sym(es1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: tally symbols per frame, close a frame on in_last or
  // when the frame reaches its length limit, and predict the published
  // word one cycle later (counts above 31 show as 31 with the sat flag).
  task automatic modelBeat(input logic v, input logic [2:0] sym, input logic last);
    exp_t e;
    logic legal;
    if (!v) return;
    legal = (sym <= 3'd4);
    if (!legal) errQ.push_back(cyc + 1);
    for (int d = 0; d < 2; d++) begin
      if (legal) begin
        mCnt[d][int'(sym)]++;
        mLen[d]++;
      end
      if (last || (legal && mLen[d] == maxF[d])) begin
        e.stamp = cyc + 1;
        e.word  = '0;
        e.sat   = 1'b0;
        for (int s = 0; s < SYM_NUM; s++) begin
          e.word = (e.word << CNT_W) | FREQ_W'((mCnt[d][s] > 31) ? 31 : mCnt[d][s]);
          if (mCnt[d][s] > 31) e.sat = 1'b1;
          mCnt[d][s] = 0;
        end
        mLen[d] = 0;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask

  task automatic modelClear();
    for (int d = 0; d < 2; d++) begin
      mLen[d] = 0;
      for (int s = 0; s < SYM_NUM; s++) mCnt[d][s] = 0;
    end
    q0.delete();
    q1.delete();
    errQ.delete();
  endtask

  // Drive one beat for the next rising edge and record its expectation.
  task automatic applyStimulus(input logic v, input logic [2:0] sym, input logic last);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_symbol = sym;
    in_last   = last;
    modelBeat(v, sym, last);
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    modelClear();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Compare one instance against the scoreboard head for this cycle; when
  // no frame is due, the published word must stay where it was.
  task automatic checkOutput(input int d, input logic v, input logic [FREQ_W-1:0] w,
                             input logic s);
    exp_t head;
    logic have;
    have = 1'b0;
    if (d == 0) begin
      while (q0.size() > 0 && q0[0].stamp < cyc) begin
        checks++; errors++;
        $display("[TB] FAIL frame_missing dut%0d: expected word %h at cycle %0d never seen", d, q0[0].word, q0[0].stamp);
        void'(q0.pop_front());
      end
      if (q0.size() > 0 && q0[0].stamp == cyc) begin
        have = 1'b1;
        head = q0.pop_front();
      end
    end else begin
      while (q1.size() > 0 && q1[0].stamp < cyc) begin
        checks++; errors++;
        $display("[TB] FAIL frame_missing dut%0d: expected word %h at cycle %0d never seen", d, q1[0].word, q1[0].stamp);
        void'(q1.pop_front());
      end
      if (q1.size() > 0 && q1[0].stamp == cyc) begin
        have = 1'b1;
        head = q1.pop_front();
      end
    end
    checks++;
    if (have || v) begin
      if (v !== have) begin
        errors++;
        $display("[TB] FAIL out_valid dut%0d cycle %0d: got %b expected %b", d, cyc, v, have);
      end else if (w !== head.word || s !== head.sat) begin
        errors++;
        $display("[TB] FAIL symbol_freq dut%0d cycle %0d: got %h sat %b expected %h sat %b", d, cyc, w, s, head.word, head.sat);
      end
      if (have) begin
        heldW[d] = head.word;
        heldS[d] = head.sat;
      end
    end else if (w !== heldW[d] || s !== heldS[d]) begin
      errors++;
      $display("[TB] FAIL hold dut%0d cycle %0d: got %h sat %b expected %h sat %b", d, cyc, w, s, heldW[d], heldS[d]);
    end
  endtask

  task automatic checkReset(input int d, input logic v, input logic [FREQ_W-1:0] w,
                            input logic s, input logic e);
    checks++;
    if (v !== 1'b0 || w !== '0 || s !== 1'b0 || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs dut%0d: got v=%b w=%h sat=%b err=%b expected all 0", d, v, w, s, e);
    end
    heldW[d] = '0;
    heldS[d] = 1'b0;
  endtask

  // Monitor: sample away from the active edge, pop and compare.
  always @(negedge clk) begin
    logic expE;
    if (!rst_n) begin
      checkReset(0, ov0, sf0, os0, es0);
      checkReset(1, ov1, sf1, os1, es1);
    end else begin
      checkOutput(0, ov0, sf0, os0);
      checkOutput(1, ov1, sf1, os1);
      expE = 1'b0;
      while (errQ.size() > 0 && errQ[0] < cyc) void'(errQ.pop_front());
      if (errQ.size() > 0 && errQ[0] == cyc) begin
        expE = 1'b1;
        void'(errQ.pop_front());
      end
      if (expE || es0 || es1) begin
        checks++;
        if (es0 !== expE || es1 !== expE) begin
          errors++;
          $display("[TB] FAIL err_sym cycle %0d: got %b/%b expected %b", cyc, es0, es1, expE);
        end
      end
    end
    if (endReq) begin
      checks++;
      if (q0.size() != 0 || q1.size() != 0 || errQ.size() != 0) begin
        errors++;
        $display("[TB] FAIL drain: got %0d/%0d/%0d pending expected 0/0/0", q0.size(), q1.size(), errQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    heldW = '{default: '0};
    heldS = '{default: 1'b0};
    modelClear();
    doReset(3);

    // a,a,b,c,c,c,e with last on e
    applyStimulus(1, SYM_A, 0);
    applyStimulus(1, SYM_A, 0);
    applyStimulus(1, SYM_B, 0);
    repeat (3) applyStimulus(1, SYM_C, 0);
    applyStimulus(1, SYM_E, 1);
    applyIdle(3);

    // 31 x d (forced end on the short-frame instance), then d,last
    repeat (31) applyStimulus(1, SYM_D, 0);
    applyStimulus(1, SYM_D, 1);
    applyIdle(2);

    // 33 x b then b,last: saturation on the long-frame instance
    repeat (33) applyStimulus(1, SYM_B, 0);
    applyStimulus(1, SYM_B, 1);
    applyIdle(2);

    // in_last on the very beat that also reaches the length limit
    repeat (30) applyStimulus(1, SYM_A, 0);
    applyStimulus(1, SYM_A, 1);
    applyIdle(2);

    // back-to-back frames: (a,last) then (e,e,last)
    applyStimulus(1, SYM_A, 1);
    applyStimulus(1, SYM_E, 0);
    applyStimulus(1, SYM_E, 1);
    applyIdle(2);

    // illegal symbols mid-frame and as the closing beat
    applyStimulus(1, SYM_A, 0);
    applyStimulus(1, SYM_B, 0);
    applyStimulus(1, 3'd6, 0);
    applyStimulus(1, SYM_C, 0);
    applyStimulus(1, 3'd7, 1);
    applyIdle(2);

    // illegal closing beat with no frame open
    applyStimulus(1, 3'd5, 1);
    applyIdle(2);

    // reset mid-frame discards the partial counts
    applyStimulus(1, SYM_A, 0);
    applyStimulus(1, SYM_B, 0);
    applyStimulus(1, SYM_C, 0);
    doReset(2);
    applyStimulus(1, SYM_C, 1);
    applyIdle(2);

    // random traffic, short frames
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 9) < 8),
                    ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7)),
                    1'($urandom_range(0, 9) == 0));
    end

    // random traffic, long frames dominated by one symbol
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 9) < 9),
                    ($urandom_range(0, 3) != 0) ? SYM_C : 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 59) == 0));
    end

    applyIdle(3);
    endReq = 1'b1;
    repeat (5) @(posedge clk);
    $display("[TB] FAIL end_of_run: monitor did not close the run");
    $fatal(1, "[TB] monitor did not finish");
  end

endmodule
